// File: rtl/pll_seq_defines.sv
// Shared state encodings and default timing constants for the PLL lock sequencer.
package pll_seq_defines;

  typedef enum logic [2:0] {
    StPwrdn    = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StHold     = 3'd3,
    StRun      = 3'd4,
    StFail     = 3'd5
  } pll_state_e;

  localparam int unsigned DefPwrdnCycles = 32;
  localparam int unsigned DefLockTimeout = 4096;
  localparam int unsigned DefLockStable  = 256;
  localparam int unsigned DefRstHold     = 16;
  localparam int unsigned DefMaxRetry    = 3;
  localparam int unsigned DefCntW        = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer; output resets to zero.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/lock supervisor: sequences POWERDOWN, qualifies LOCK, releases system reset,
// retries on timeout and latches a sticky failure after the retry budget is spent.
module pll_lock_sequencer
  import pll_seq_defines::*;
#(
  parameter int unsigned PWRDN_CYCLES = DefPwrdnCycles,
  parameter int unsigned LOCK_TIMEOUT = DefLockTimeout,
  parameter int unsigned LOCK_STABLE  = DefLockStable,
  parameter int unsigned RST_HOLD     = DefRstHold,
  parameter int unsigned MAX_RETRY    = DefMaxRetry,
  parameter int unsigned CNT_W        = DefCntW
) (
  input  logic       sys_clk_i,
  input  logic       rst_n_pad_i,
  input  logic       pll_lock_i,
  input  logic       restart_i,
  output logic       pll_powerdown_n_o,
  output logic       sys_rst_o,
  output logic       pll_ready_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] PwrdnLast   = CNT_W'(PWRDN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(RST_HOLD - 1);
  localparam logic [3:0]       RetryMax    = 4'(MAX_RETRY);

  logic lock_s;

  sync_2ff #(
    .Width (1)
  ) u_lock_sync (
    .clk_i  (sys_clk_i),
    .rst_ni (rst_n_pad_i),
    .d_i    (pll_lock_i),
    .q_o    (lock_s)
  );

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             pd_n_q, pd_n_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;

    unique case (state_q)
      StPwrdn: begin
        if (cnt_q == PwrdnLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (lock_s) begin
          state_d = StStable;
        end else if (cnt_q == TimeoutLast) begin
          if (retry_q == RetryMax) begin
            state_d = StFail;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = StPwrdn;
          end
        end
      end
      StStable: begin
        if (!lock_s) state_d = StWaitLock;
        else if (cnt_q == StableLast) state_d = StHold;
      end
      StHold: begin
        if (!lock_s) state_d = StWaitLock;
        else if (cnt_q == HoldLast) state_d = StRun;
      end
      StRun: begin
        if (!lock_s) begin
          state_d = StPwrdn;
          retry_d = '0;
        end
      end
      StFail: state_d = StFail;
      default: state_d = StPwrdn;
    endcase

    if (restart_i) begin
      state_d = StPwrdn;
      retry_d = '0;
    end

    // Every timed state exits at its own terminal count, so the counter cannot wrap.
    if (state_d != state_q || restart_i) begin
      cnt_d = '0;
    end else if (state_q == StRun || state_q == StFail) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    pd_n_d    = !(state_d == StPwrdn || state_d == StFail);
    sys_rst_d = (state_d != StRun);
    ready_d   = (state_d == StRun);
    fail_d    = (state_d == StFail);
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      state_q   <= StPwrdn;
      cnt_q     <= '0;
      retry_q   <= '0;
      pd_n_q    <= 1'b0;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pd_n_q    <= pd_n_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_powerdown_n_o = pd_n_q;
  assign sys_rst_o         = sys_rst_q;
  assign pll_ready_o       = ready_q;
  assign fail_o            = fail_q;
  assign retry_cnt_o       = retry_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters and hand-derived edge numbers.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       pd_n, sys_rst, ready, fail;
  logic [3:0] retry;
  logic [2:0] state;

  int n_total = 0;
  int n_bad = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .PWRDN_CYCLES (4),
    .LOCK_TIMEOUT (16),
    .LOCK_STABLE  (8),
    .RST_HOLD     (4),
    .MAX_RETRY    (2),
    .CNT_W        (16)
  ) dut (
    .sys_clk_i         (clk),
    .rst_n_pad_i       (rst_n),
    .pll_lock_i        (pll_lock),
    .restart_i         (restart),
    .pll_powerdown_n_o (pd_n),
    .sys_rst_o         (sys_rst),
    .pll_ready_o       (ready),
    .fail_o            (fail),
    .retry_cnt_o       (retry),
    .state_o           (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e_pd, input logic e_rst,
                           input logic e_rdy, input logic e_fail);
    check_eq({tag, ".pd_n"}, {31'd0, pd_n}, {31'd0, e_pd});
    check_eq({tag, ".sys_rst"}, {31'd0, sys_rst}, {31'd0, e_rst});
    check_eq({tag, ".ready"}, {31'd0, ready}, {31'd0, e_rdy});
    check_eq({tag, ".fail"}, {31'd0, fail}, {31'd0, e_fail});
  endtask

  // Edge 1 is the first rising edge after release; lock is applied before release.
  task automatic do_reset(input logic lock_val);
    rst_n = 1'b0;
    restart = 1'b0;
    pll_lock = lock_val;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  initial begin
    // Lock high from reset: nominal bring-up
    do_reset(1'b1);
    #1;
    check_out("rst", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("rst.state", 32'(state), 32'd0);
    check_eq("rst.retry", 32'(retry), 32'd0);
    run_to(3);
    check_out("nom.e3", 1'b0, 1'b1, 1'b0, 1'b0);
    run_to(4);
    check_out("nom.e4", 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("nom.e4.state", 32'(state), 32'd1);
    run_to(5);
    check_eq("nom.e5.state", 32'(state), 32'd2);
    run_to(16);
    check_out("nom.e16", 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("nom.e16.state", 32'(state), 32'd3);
    run_to(17);
    check_out("nom.e17", 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("nom.e17.state", 32'(state), 32'd4);
    check_eq("nom.e17.retry", 32'(retry), 32'd0);

    // Lock tied low: two retries then FAIL on edge 60, then restart
    do_reset(1'b0);
    run_to(19);
    check_eq("low.e19.retry", 32'(retry), 32'd0);
    check_eq("low.e19.state", 32'(state), 32'd1);
    run_to(20);
    check_eq("low.e20.retry", 32'(retry), 32'd1);
    check_eq("low.e20.state", 32'(state), 32'd0);
    check_out("low.e20", 1'b0, 1'b1, 1'b0, 1'b0);
    run_to(40);
    check_eq("low.e40.retry", 32'(retry), 32'd2);
    run_to(59);
    check_out("low.e59", 1'b1, 1'b1, 1'b0, 1'b0);
    run_to(60);
    check_out("low.e60", 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("low.e60.state", 32'(state), 32'd5);
    run_to(70);
    check_out("low.e70", 1'b0, 1'b1, 1'b0, 1'b1);
    restart = 1'b1;
    run_to(71);
    restart = 1'b0;
    check_out("fail.restart", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("fail.restart.state", 32'(state), 32'd0);
    check_eq("fail.restart.retry", 32'(retry), 32'd0);

    // restart coincident with a WAIT_LOCK timeout wins over the retry increment
    do_reset(1'b0);
    run_to(19);
    restart = 1'b1;
    run_to(20);
    restart = 1'b0;
    check_eq("rs_to.state", 32'(state), 32'd0);
    check_eq("rs_to.retry", 32'(retry), 32'd0);
    check_out("rs_to", 1'b0, 1'b1, 1'b0, 1'b0);
    run_to(23);
    check_eq("rs_to.e23.pd_n", 32'(pd_n), 32'd0);
    run_to(24);
    check_eq("rs_to.e24.pd_n", 32'(pd_n), 32'd1);

    // One-cycle lock drop mid-STABLE: back to WAIT_LOCK, full STABLE recount
    do_reset(1'b1);
    run_to(8);
    pll_lock = 1'b0;
    run_to(9);
    pll_lock = 1'b1;
    run_to(10);
    check_eq("glitch.e10.state", 32'(state), 32'd2);
    run_to(11);
    check_eq("glitch.e11.state", 32'(state), 32'd1);
    run_to(12);
    check_eq("glitch.e12.state", 32'(state), 32'd2);
    run_to(19);
    check_eq("glitch.e19.state", 32'(state), 32'd2);
    run_to(20);
    check_eq("glitch.e20.state", 32'(state), 32'd3);
    run_to(23);
    check_out("glitch.e23", 1'b1, 1'b1, 1'b0, 1'b0);
    run_to(24);
    check_out("glitch.e24", 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("glitch.e24.retry", 32'(retry), 32'd0);

    // Lock after one retry, then lock loss in RUN clears retry and re-sequences
    do_reset(1'b0);
    run_to(20);
    check_eq("run.e20.retry", 32'(retry), 32'd1);
    pll_lock = 1'b1;
    run_to(36);
    check_out("run.e36", 1'b1, 1'b1, 1'b0, 1'b0);
    run_to(37);
    check_out("run.e37", 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("run.e37.retry", 32'(retry), 32'd1);
    run_to(40);
    pll_lock = 1'b0;
    run_to(42);
    check_out("drop.e42", 1'b1, 1'b0, 1'b1, 1'b0);
    run_to(43);
    check_out("drop.e43", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("drop.e43.state", 32'(state), 32'd0);
    check_eq("drop.e43.retry", 32'(retry), 32'd0);
    pll_lock = 1'b1;
    run_to(47);
    check_eq("relock.e47.pd_n", 32'(pd_n), 32'd1);
    run_to(59);
    check_out("relock.e59", 1'b1, 1'b1, 1'b0, 1'b0);
    run_to(60);
    check_out("relock.e60", 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("relock.e60.retry", 32'(retry), 32'd0);

    // Asynchronous reset in RUN: outputs return to reset values before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    check_out("areset", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("areset.state", 32'(state), 32'd0);
    check_eq("areset.retry", 32'(retry), 32'd0);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Power-up and lock supervisor for the board PLL. Runs on the free-running 25 MHz crystal clock and drives the PLL's active-low POWERDOWN. It waits for a synchronized, stable LOCK, then releases the system reset to the PLL-clocked Wishbone domain. It retries on lock timeout, re-sequences on lock loss, and latches a sticky failure after a bounded number of retries. It sits between the reset pad and the PLL core, ahead of the clock/reset distribution.

## Interface
- PWRDN_CYCLES, 32: cycles POWERDOWN is held asserted per attempt (≥2)
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before an attempt fails
- LOCK_STABLE, 256: consecutive synchronized-lock cycles required
- RST_HOLD, 16: cycles sys_rst_o stays asserted after lock is stable
- MAX_RETRY, 3: retries after the first attempt (≤15)
- CNT_W, 16: shared counter width; every cycle parameter must be ≤2^CNT_W
- sys_clk_i  in  1  crystal clock (not a PLL output)
- rst_n_pad_i  in  1  reset, asynchronous, active-low
- pll_lock_i  in  1  PLL LOCK, asynchronous to sys_clk_i
- restart_i  in  1  synchronous pulse requesting a full re-sequence
- pll_powerdown_n_o  out  1  to PLL POWERDOWN; 0 = PLL powered down
- sys_rst_o  out  1  active-high reset for PLL-clocked logic
- pll_ready_o  out  1  high only in RUN
- fail_o  out  1  high only in FAIL
- retry_cnt_o  out  4  retries consumed in the current sequence
- state_o  out  3  state encoding, for debug

## Operation
- pll_lock_i passes through a 2-flop synchronizer (lock_s), which resets to 0. Only lock_s is used internally.
- States: PWRDN, WAIT_LOCK, STABLE, HOLD, RUN, FAIL. One CNT_W counter is cleared on every state entry.
- PWRDN: powerdown_n=0, sys_rst=1. When cnt==PWRDN_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK: powerdown_n=1, sys_rst=1.
  - If lock_s=1, go to STABLE.
  - Else if cnt==LOCK_TIMEOUT-1: if retry==MAX_RETRY go to FAIL; otherwise retry+1 and go to PWRDN.
- STABLE: if lock_s=0, go to WAIT_LOCK (timeout restarts; retry unchanged). If lock_s=1 and cnt==LOCK_STABLE-1, go to HOLD.
- HOLD: sys_rst=1. If lock_s=0, go to WAIT_LOCK. If cnt==RST_HOLD-1, go to RUN.
- RUN: sys_rst=0, ready=1. If lock_s=0, go to PWRDN with retry cleared to 0 (fresh sequence).
- FAIL: powerdown_n=0, sys_rst=1, fail=1. Exits only via restart_i or reset.
- restart_i=1 in any state: go to PWRDN, retry cleared. It has priority over every other transition in the same cycle.
- Simultaneous lock_s drop and completion count: the drop wins, because completion requires lock_s=1.
- Lock events in PWRDN are ignored.

## Timing
- Reset values (asynchronous): state=PWRDN, cnt=0, retry=0, pll_powerdown_n_o=0, sys_rst_o=1, pll_ready_o=0, fail_o=0, state_o=PWRDN encoding.
- All outputs are registered and Moore-decoded from the next state, so they change on the same edge as state.
- Lock latency: pll_lock_i to lock_s is 2 edges. A lock drop in RUN raises sys_rst_o 3 edges after pll_lock_i falls.
- Nominal bring-up with lock high throughout: sys_rst_o falls on edge PWRDN_CYCLES+1+LOCK_STABLE+RST_HOLD. Edge 1 is the first rising edge after reset release.
- Worst case to FAIL with no lock: (MAX_RETRY+1)×(PWRDN_CYCLES+LOCK_TIMEOUT) edges.
- Counter never wraps; each compare is an equality at parameter-1.
- Reset mid-operation: PLL is powered down and sys_rst_o is asserted immediately (asynchronous).

## Structure
- Shared package/include pll_seq_defines: 3-bit state encodings (PWRDN=0, WAIT_LOCK=1, STABLE=2, HOLD=3, RUN=4, FAIL=5) and default parameter constants.
- Sub-module sync_2ff: generic 2-flop synchronizer with asynchronous active-low reset, reused for lock_s.
- Everything else (FSM, counter, retry register, output decode) lives in pll_lock_sequencer.

## Test plan
All scenarios use PWRDN_CYCLES=4, LOCK_TIMEOUT=16, LOCK_STABLE=8, RST_HOLD=4, MAX_RETRY=2.
- Lock tied high from reset -> pll_powerdown_n_o rises on edge 4; sys_rst_o falls and pll_ready_o rises on edge 17; retry_cnt_o=0.
- Lock tied low -> retry_cnt_o steps 1, 2; fail_o rises on edge 60; pll_powerdown_n_o=0 and sys_rst_o=1 thereafter.
- Lock drops for 1 cycle mid-STABLE -> state returns to WAIT_LOCK, then STABLE restarts the full 8-cycle count; sys_rst_o release is delayed accordingly; retry_cnt_o unchanged.
- Lock drops in RUN -> sys_rst_o=1 and pll_ready_o=0 within 3 edges; state PWRDN; retry_cnt_o=0; re-lock repeats the 17-edge sequence.
- restart_i pulsed in FAIL, and restart_i coincident with a WAIT_LOCK timeout -> PWRDN next edge, fail_o=0, retry_cnt_o=0.
- rst_n_pad_i asserted asynchronously in RUN -> all outputs at reset values before the next clock edge.
